// File: rtl/phy_mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter sequencing one shared memory path.
// Data port has priority; a streak counter lets a waiting fetch in after STARVE_LIMIT data grants.
module phy_mem_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_HOLD   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        if_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic        mem_is_write,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy
);
  localparam int CMAX = (READ_CYCLES > WRITE_HOLD) ? READ_CYCLES : WRITE_HOLD;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST = CW'(WRITE_HOLD - 1);
  localparam logic [SW-1:0] S_MAX   = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          gnt_data_q, gnt_data_d;
  logic          err_pend_q, err_pend_d;
  logic          if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic          if_err_q, if_err_d, d_err_q, d_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_data_in_q, mem_data_in_d;
  logic          mem_is_write_q, mem_is_write_d;

  logic        if_elig, d_elig, guard, grant_d, grant_i;
  logic [31:0] g_addr;

  // A port whose ack is showing this cycle is still holding req for the finished request.
  assign if_elig = if_req && !if_ack_q;
  assign d_elig  = d_req && !d_ack_q;
  assign guard   = (STARVE_LIMIT != 0) && (streak_q == S_MAX) && if_elig;
  assign grant_d = d_elig && !guard;
  assign grant_i = if_elig && !grant_d;
  assign g_addr  = grant_d ? d_addr : if_addr;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    streak_d       = streak_q;
    gnt_data_d     = gnt_data_q;
    err_pend_d     = err_pend_q;
    if_ack_d       = 1'b0;
    d_ack_d        = 1'b0;
    if_err_d       = 1'b0;
    d_err_d        = 1'b0;
    if_rdata_d     = if_rdata_q;
    d_rdata_d      = d_rdata_q;
    mem_addr_d     = mem_addr_q;
    mem_data_in_d  = mem_data_in_q;
    mem_is_write_d = mem_is_write_q;
    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          // Rejected request: answer without touching the memory path.
          err_pend_d = 1'b0;
          if (gnt_data_q) begin
            d_ack_d   = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else if (grant_d || grant_i) begin
          gnt_data_d = grant_d;
          cnt_d      = '0;
          if (grant_i || !if_elig) begin
            streak_d = '0;
          end else if (streak_q != S_MAX) begin
            streak_d = streak_q + SW'(1);
          end
          if (g_addr[1:0] != 2'b00) begin
            err_pend_d = 1'b1;
          end else begin
            mem_addr_d = g_addr;
            if (grant_d && d_we) begin
              mem_data_in_d  = d_wdata;
              mem_is_write_d = 1'b1;
              state_d        = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          if (gnt_data_q) begin
            d_rdata_d = mem_data_out;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_data_out;
            if_ack_d   = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR: begin
        if (cnt_q == WR_LAST) begin
          mem_is_write_d = 1'b0;
          state_d        = WR_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_WAIT: begin
        if (!mem_busy) begin
          d_ack_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      streak_q       <= '0;
      gnt_data_q     <= 1'b0;
      err_pend_q     <= 1'b0;
      if_ack_q       <= 1'b0;
      d_ack_q        <= 1'b0;
      if_err_q       <= 1'b0;
      d_err_q        <= 1'b0;
      if_rdata_q     <= '0;
      d_rdata_q      <= '0;
      mem_addr_q     <= '0;
      mem_data_in_q  <= '0;
      mem_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      streak_q       <= streak_d;
      gnt_data_q     <= gnt_data_d;
      err_pend_q     <= err_pend_d;
      if_ack_q       <= if_ack_d;
      d_ack_q        <= d_ack_d;
      if_err_q       <= if_err_d;
      d_err_q        <= d_err_d;
      if_rdata_q     <= if_rdata_d;
      d_rdata_q      <= d_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_in_q  <= mem_data_in_d;
      mem_is_write_q <= mem_is_write_d;
    end
  end

  assign if_rdata     = if_rdata_q;
  assign if_ack       = if_ack_q;
  assign if_err       = if_err_q;
  assign d_rdata      = d_rdata_q;
  assign d_ack        = d_ack_q;
  assign d_err        = d_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_is_write = mem_is_write_q;
endmodule

// File: tb/tb_phy_mem_arbiter.sv
// Bench for phy_mem_arbiter: directed scenarios plus random traffic against a transaction-timing model.
module tb_phy_mem_arbiter;
  localparam int RC = 2;
  localparam int WH = 2;
  localparam int SL = 4;
  localparam int K_RD = 0, K_WR = 1, K_ERR = 2;

  logic        clk50M = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] mem_data_out = '0;
  logic        mem_busy = 1'b0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_data_in;
  logic        if_ack, d_ack, d_err, if_err, mem_is_write;

  int vecs = 0;
  int errs = 0;

  always #5 clk50M = ~clk50M;

  phy_mem_arbiter #(.READ_CYCLES(RC), .WRITE_HOLD(WH), .STARVE_LIMIT(SL)) dut (
    .clk50M(clk50M), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .if_err(if_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_is_write(mem_is_write),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy)
  );

  // Reference model: one transaction in flight, completion timed from its grant edge.
  longint      cyc, m_t0;
  bit          m_tx, m_port_d;
  int          m_kind, m_streak;
  bit          e_if_ack, e_d_ack, e_if_err, e_d_err, e_mem_is_write;
  logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_data_in;

  always @(posedge clk50M or negedge rst_n) begin
    bit ie, de, gd, gi, old_if_ack, old_d_ack;
    logic [31:0] a;
    if (!rst_n) begin
      cyc = 0; m_t0 = 0; m_tx = 0; m_port_d = 0; m_kind = K_RD; m_streak = 0;
      e_if_ack = 0; e_d_ack = 0; e_if_err = 0; e_d_err = 0; e_mem_is_write = 0;
      e_if_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_data_in = '0;
    end else begin
      cyc++;
      old_if_ack = e_if_ack;
      old_d_ack  = e_d_ack;
      e_if_ack = 0; e_d_ack = 0; e_if_err = 0; e_d_err = 0;
      if (m_tx) begin
        if (m_kind == K_RD && cyc == m_t0 + RC) begin
          if (m_port_d) begin e_d_rdata = mem_data_out; e_d_ack = 1; end
          else begin e_if_rdata = mem_data_out; e_if_ack = 1; end
          m_tx = 0;
        end else if (m_kind == K_WR) begin
          if (cyc == m_t0 + WH) e_mem_is_write = 0;
          if (cyc >= m_t0 + WH + 1 && !mem_busy) begin e_d_ack = 1; m_tx = 0; end
        end else if (m_kind == K_ERR && cyc == m_t0 + 1) begin
          if (m_port_d) begin e_d_ack = 1; e_d_err = 1; e_d_rdata = '0; end
          else begin e_if_ack = 1; e_if_err = 1; e_if_rdata = '0; end
          m_tx = 0;
        end
      end else begin
        ie = if_req && !old_if_ack;
        de = d_req && !old_d_ack;
        gd = de && !(SL != 0 && m_streak == SL && ie);
        gi = ie && !gd;
        if (gd || gi) begin
          if (gi || !ie) m_streak = 0;
          else m_streak = (m_streak < SL) ? m_streak + 1 : SL;
          a = gd ? d_addr : if_addr;
          m_tx = 1; m_t0 = cyc; m_port_d = gd;
          if (a[1:0] != 2'b00) m_kind = K_ERR;
          else begin
            e_mem_addr = a;
            if (gd && d_we) begin
              m_kind = K_WR; e_mem_data_in = d_wdata; e_mem_is_write = 1;
            end else m_kind = K_RD;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk50M);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; if_req = 0; d_req = 0; d_we = 0; mem_busy = 0;
    repeat (2) @(posedge clk50M);
    @(negedge clk50M);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1;
    vecs++;
    if ({if_ack, d_ack, if_err, d_err, mem_is_write} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 00000", {if_ack, d_ack, if_err, d_err, mem_is_write});
    end
    vecs++;
    if ({if_rdata, d_rdata, mem_addr, mem_data_in} !== 128'b0) begin
      errs++; $display("FAIL reset_data: got %h %h %h %h want zeros", if_rdata, d_rdata, mem_addr, mem_data_in);
    end
    if_req = 1; d_req = 1; d_addr = 32'h40; if_addr = 32'h80;
    repeat (2) tick();
    vecs++;
    if ({if_ack, d_ack, mem_is_write, mem_addr} !== 35'b0) begin
      errs++; $display("FAIL reset_held: got ack %b %b wr %b addr %h want 0", if_ack, d_ack, mem_is_write, mem_addr);
    end
  endtask

  task automatic test_read();
    do_reset();
    if_addr = 32'h10; mem_data_out = 32'hDEADBEEF; if_req = 1;
    tick();
    vecs++;
    if (mem_addr !== 32'h10 || if_ack !== 1'b0) begin
      errs++; $display("FAIL read_grant: addr %h ack %b want 00000010 0", mem_addr, if_ack);
    end
    tick();
    vecs++;
    if (if_ack !== 1'b0 || mem_is_write !== 1'b0) begin
      errs++; $display("FAIL read_early: ack %b wr %b want 0 0", if_ack, mem_is_write);
    end
    tick();
    vecs++;
    if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF || if_err !== 1'b0 || mem_is_write !== 1'b0) begin
      errs++; $display("FAIL read_ack: ack %b data %h err %b want 1 deadbeef 0", if_ack, if_rdata, if_err);
    end
    if_req = 0;
    tick();
    vecs++;
    if (if_ack !== 1'b0) begin
      errs++; $display("FAIL read_ack_pulse: ack %b want 0", if_ack);
    end
  endtask

  task automatic test_write();
    do_reset();
    d_addr = 32'h20; d_wdata = 32'h12345678; d_we = 1; d_req = 1;
    for (int k = 0; k < WH; k++) begin
      tick();
      vecs++;
      if (mem_is_write !== 1'b1 || mem_data_in !== 32'h12345678 || mem_addr !== 32'h20 || d_ack !== 1'b0) begin
        errs++; $display("FAIL write_pulse%0d: wr %b din %h addr %h ack %b want 1 12345678 20 0", k, mem_is_write, mem_data_in, mem_addr, d_ack);
      end
    end
    tick();
    vecs++;
    if (mem_is_write !== 1'b0) begin
      errs++; $display("FAIL write_fall: wr %b want 0", mem_is_write);
    end
    mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vecs++;
      if (d_ack !== 1'b0 || mem_is_write !== 1'b0) begin
        errs++; $display("FAIL write_busy%0d: ack %b wr %b want 0 0", k, d_ack, mem_is_write);
      end
    end
    mem_busy = 0;
    tick();
    vecs++;
    if (d_ack !== 1'b1 || d_err !== 1'b0 || mem_data_in !== 32'h12345678) begin
      errs++; $display("FAIL write_ack: ack %b err %b din %h want 1 0 12345678", d_ack, d_err, mem_data_in);
    end
    d_req = 0;
  endtask

  task automatic test_unaligned();
    tick();
    d_addr = 32'h22; d_wdata = 32'hFFFFFFFF; d_we = 1; d_req = 1;
    tick();
    vecs++;
    if (mem_addr !== 32'h20 || mem_is_write !== 1'b0 || mem_data_in !== 32'h12345678 || d_ack !== 1'b0) begin
      errs++; $display("FAIL unaligned_grant: addr %h wr %b din %h ack %b want 20 0 12345678 0", mem_addr, mem_is_write, mem_data_in, d_ack);
    end
    tick();
    vecs++;
    if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0 || mem_addr !== 32'h20 || mem_is_write !== 1'b0) begin
      errs++; $display("FAIL unaligned_ack: ack %b err %b rdata %h addr %h want 1 1 0 20", d_ack, d_err, d_rdata, mem_addr);
    end
    d_req = 0;
    tick();
    vecs++;
    if (d_ack !== 1'b0 || d_err !== 1'b0) begin
      errs++; $display("FAIL unaligned_pulse: ack %b err %b want 0 0", d_ack, d_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_addr = 32'h40; if_req = 1;
    for (int k = 0; k < 16; k++) begin
      bit exp;
      mem_data_out = 32'h1000 + k;
      tick();
      exp = (k >= RC) && ((k - RC) % (RC + 2) == 0);
      vecs++;
      if (if_ack !== exp) begin
        errs++; $display("FAIL hold_req_cycle%0d: ack %b want %b", k, if_ack, exp);
      end
    end
    if_req = 0;
  endtask

  task automatic test_starvation();
    int seq[$];
    int guard_cnt;
    do_reset();
    d_addr = 32'h100; d_we = 0; if_addr = 32'h200;
    guard_cnt = 0;
    while (seq.size() < 10 && guard_cnt < 400) begin
      // Fetch asks only when data is about to win, so each data grant sees a waiting fetch.
      d_req  = !e_if_ack;
      if_req = (!m_tx && d_req && !e_d_ack) || (m_tx && !m_port_d);
      mem_data_out = $urandom;
      tick();
      guard_cnt++;
      if (if_ack && d_ack) begin
        vecs++; errs++; $display("FAIL starve_dual_ack at cycle %0d: both acks high", guard_cnt);
      end
      if (d_ack) seq.push_back(1);
      if (if_ack) seq.push_back(0);
    end
    d_req = 0; if_req = 0;
    vecs++;
    if (seq.size() != 10) begin
      errs++; $display("FAIL starve_count: got %0d acks want 10", seq.size());
    end
    for (int i = 0; i < seq.size() && i < 10; i++) begin
      int exp;
      exp = ((i % (SL + 1)) == SL) ? 0 : 1;
      vecs++;
      if (seq[i] != exp) begin
        errs++; $display("FAIL starve_order%0d: got %s want %s", i, seq[i] ? "D" : "I", exp ? "D" : "I");
      end
    end
  endtask

  task automatic test_reset_midwrite();
    bit got;
    do_reset();
    d_addr = 32'h300; d_wdata = 32'hCAFEF00D; d_we = 1; d_req = 1;
    tick();
    tick();
    vecs++;
    if (mem_is_write !== 1'b1) begin
      errs++; $display("FAIL midreset_pre: wr %b want 1", mem_is_write);
    end
    #2;
    rst_n = 0;
    #1;
    vecs++;
    if (mem_is_write !== 1'b0 || d_ack !== 1'b0 || mem_addr !== 32'h0 || mem_data_in !== 32'h0) begin
      errs++; $display("FAIL midreset_async: wr %b ack %b addr %h din %h want 0 0 0 0", mem_is_write, d_ack, mem_addr, mem_data_in);
    end
    d_req = 0;
    @(negedge clk50M);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (d_ack !== 1'b0 || mem_is_write !== 1'b0) begin
        errs++; $display("FAIL midreset_noack%0d: ack %b wr %b want 0 0", k, d_ack, mem_is_write);
      end
    end
    if_addr = 32'h80; mem_data_out = 32'h5A5A1234; if_req = 1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (if_ack) got = 1;
    end
    if_req = 0;
    vecs++;
    if (!got || if_rdata !== 32'h5A5A1234 || mem_addr !== 32'h80) begin
      errs++; $display("FAIL midreset_read: ack_seen %b data %h addr %h want 1 5a5a1234 80", got, if_rdata, mem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if_req = ($urandom_range(0, 3) != 0);
      d_req  = ($urandom_range(0, 3) != 0);
      d_we   = $urandom_range(0, 1);
      t = $urandom; t[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00; if_addr = t;
      t = $urandom; t[1:0] = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'b00; d_addr = t;
      d_wdata = $urandom;
      mem_data_out = $urandom;
      mem_busy = ($urandom_range(0, 2) == 0);
      tick();
      vecs++;
      if ({if_ack, if_err, if_rdata} !== {e_if_ack, e_if_err, e_if_rdata}) begin
        errs++; $display("FAIL rand_if@%0d: ack %b err %b data %h want %b %b %h", n, if_ack, if_err, if_rdata, e_if_ack, e_if_err, e_if_rdata);
      end
      vecs++;
      if ({d_ack, d_err, d_rdata} !== {e_d_ack, e_d_err, e_d_rdata}) begin
        errs++; $display("FAIL rand_d@%0d: ack %b err %b data %h want %b %b %h", n, d_ack, d_err, d_rdata, e_d_ack, e_d_err, e_d_rdata);
      end
      vecs++;
      if ({mem_is_write, mem_addr, mem_data_in} !== {e_mem_is_write, e_mem_addr, e_mem_data_in}) begin
        errs++; $display("FAIL rand_mem@%0d: wr %b addr %h din %h want %b %h %h", n, mem_is_write, mem_addr, mem_data_in, e_mem_is_write, e_mem_addr, e_mem_data_in);
      end
    end
    if_req = 0; d_req = 0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unaligned();
    test_back_to_back();
    test_starvation();
    test_reset_midwrite();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
